codec_sample_capture: RTL and testbench

Capture-side counterpart to the playback conditioner: takes the 18-bit ADC sample the ac97 codec presents with each `new_frame`, latches it exactly once per frame, and buffers it in a small FIFO. Samples are handed to the 100 MHz system logic through a valid/ack handshake. It sits between the codec's record path and any consumer (recorder, effects, meters), so consumers need not track the 48 kHz frame timing. Overruns are counted and flagged, never silently corrupted.

---
 rtl/codec_sample_capture_pkg.sv | 11 +
 rtl/codec_sample_capture_sample_fifo.sv | 57 +++++
 rtl/codec_sample_capture.sv | 67 ++++++
 tb/tb_codec_sample_capture.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_sample_capture_pkg.sv
// Shared constants and helpers for the codec record-side capture path.
package codec_sample_capture_pkg;

    localparam int         CODEC_SAMPLE_WIDTH = 18;
    localparam logic [7:0] DROP_MAX           = 8'hFF;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == DROP_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/codec_sample_capture_sample_fifo.sv
// Small power-of-two FIFO for captured codec samples.
// A pop frees a slot in the same cycle, so a full FIFO can accept a push.
module codec_sample_capture_sample_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic             pop_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic             push_dropped
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push;
    logic             pop;

    assign empty        = (count == '0);
    assign full         = (count == FULL_CNT);
    assign pop          = pop_req & ~empty;
    assign push         = push_req & (~full | pop);
    assign push_dropped = push_req & full & ~pop;
    assign rd_data      = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/codec_sample_capture.sv
// Latches one ADC sample per codec frame and buffers it for the system side.
module codec_sample_capture
    import codec_sample_capture_pkg::*;
#(
    parameter int WIDTH = CODEC_SAMPLE_WIDTH,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_frame,
    input  logic [WIDTH-1:0] codec_sample,
    output logic [WIDTH-1:0] sample_out,
    output logic             sample_valid,
    input  logic             sample_ack,
    output logic             overflow,
    input  logic             clear_overflow,
    output logic [7:0]       drop_count
);

    logic             prev_frame;
    logic             capture;
    logic             fifo_empty;
    logic             fifo_full;
    logic             dropped;
    logic [WIDTH-1:0] fifo_data;

    // prev_frame resets high so a frame already in progress is skipped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) prev_frame <= 1'b1;
        else       prev_frame <= new_frame;
    end

    assign capture = new_frame & ~prev_frame;

    codec_sample_capture_sample_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push_req     (capture),
        .pop_req      (sample_ack),
        .wr_data      (codec_sample),
        .rd_data      (fifo_data),
        .empty        (fifo_empty),
        .full         (fifo_full),
        .push_dropped (dropped)
    );

    // A drop outranks a simultaneous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end else if (dropped) begin
            overflow   <= 1'b1;
            drop_count <= clear_overflow ? 8'd1 : sat_inc(drop_count);
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= 8'd0;
        end
    end

    assign sample_valid = ~fifo_empty;
    assign sample_out   = fifo_empty ? '0 : fifo_data;

endmodule

// File: tb/tb_codec_sample_capture.sv
// Directed bench for codec_sample_capture with hand-computed expectations.
module tb_codec_sample_capture;

    logic        clk;
    logic        reset;
    logic        new_frame;
    logic [17:0] codec_sample;
    logic [17:0] sample_out;
    logic        sample_valid;
    logic        sample_ack;
    logic        overflow;
    logic        clear_overflow;
    logic [7:0]  drop_count;

    int n_vec;
    int n_err;

    codec_sample_capture #(
        .WIDTH (18),
        .DEPTH (4)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .new_frame      (new_frame),
        .codec_sample   (codec_sample),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_ack     (sample_ack),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Rise, hold two edges, fall for one edge.
    task automatic frame(input logic [17:0] s);
        codec_sample = s;
        new_frame = 1'b1;
        @(negedge clk);
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        new_frame = 1'b0;
        codec_sample = '0;
        sample_ack = 1'b0;
        clear_overflow = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(sample_valid), 32'd0);
        chk("rst_out", 32'(sample_out), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_drop", 32'(drop_count), 32'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Single long frame
        codec_sample = 18'h1A2B3;
        new_frame = 1'b1;
        #1;
        chk("no_bypass", 32'(sample_valid), 32'd0);
        @(negedge clk);
        chk("single_valid", 32'(sample_valid), 32'd1);
        chk("single_out", 32'(sample_out), 32'h1A2B3);
        repeat (19) @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        chk("single_still", 32'(sample_valid), 32'd1);
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
        chk("single_once_valid", 32'(sample_valid), 32'd0);
        chk("single_once_out", 32'(sample_out), 32'd0);

        // Fill and overflow
        for (int i = 1; i <= 6; i++) frame(18'(i));
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_order", 32'(sample_out), 32'(i));
            sample_ack = 1'b1;
            @(negedge clk);
        end
        sample_ack = 1'b0;
        chk("ovf_drained", 32'(sample_valid), 32'd0);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_drop", 32'(drop_count), 32'd0);

        // Full with simultaneous pop
        for (int i = 1; i <= 4; i++) frame(18'(i));
        chk("full_nodrop", 32'(drop_count), 32'd0);
        codec_sample = 18'd5;
        new_frame = 1'b1;
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
        chk("fpop_ovf", 32'(overflow), 32'd0);
        chk("fpop_drop", 32'(drop_count), 32'd0);
        @(negedge clk);
        new_frame = 1'b0;
        @(negedge clk);
        for (int i = 2; i <= 5; i++) begin
            chk("fpop_order", 32'(sample_out), 32'(i));
            sample_ack = 1'b1;
            @(negedge clk);
        end
        sample_ack = 1'b0;
        chk("fpop_drained", 32'(sample_valid), 32'd0);

        // Acks while empty
        sample_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("empty_ack", 32'(sample_valid), 32'd0);
        end
        codec_sample = 18'h00007;
        new_frame = 1'b1;
        @(negedge clk);
        chk("spur_valid", 32'(sample_valid), 32'd1);
        chk("spur_out", 32'(sample_out), 32'h7);
        @(negedge clk);
        chk("spur_popped", 32'(sample_valid), 32'd0);
        new_frame = 1'b0;
        sample_ack = 1'b0;
        @(negedge clk);
        chk("spur_empty", 32'(sample_valid), 32'd0);
        chk("spur_out0", 32'(sample_out), 32'd0);

        // Asynchronous reset mid-operation
        frame(18'h21);
        frame(18'h22);
        frame(18'h23);
        chk("pre_rst_out", 32'(sample_out), 32'h21);
        #2 reset = 1'b1;
        #1;
        chk("async_valid", 32'(sample_valid), 32'd0);
        chk("async_out", 32'(sample_out), 32'd0);
        new_frame = 1'b1;
        codec_sample = 18'h24;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("skip_partial", 32'(sample_valid), 32'd0);
        end
        new_frame = 1'b0;
        @(negedge clk);
        frame(18'h25);
        chk("post_rst_valid", 32'(sample_valid), 32'd1);
        chk("post_rst_out", 32'(sample_out), 32'h25);
        sample_ack = 1'b1;
        @(negedge clk);
        sample_ack = 1'b0;
        chk("post_rst_drain", 32'(sample_valid), 32'd0);

        // Saturation and clear
        for (int i = 1; i <= 4; i++) frame(18'(32'h30 + i));
        codec_sample = 18'h3FFFF;
        for (int i = 0; i < 300; i++) begin
            new_frame = 1'b1;
            @(negedge clk);
            new_frame = 1'b0;
            @(negedge clk);
        end
        chk("sat_drop", 32'(drop_count), 32'd255);
        chk("sat_ovf", 32'(overflow), 32'd1);
        chk("sat_head", 32'(sample_out), 32'h31);
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        chk("sat_clr_ovf", 32'(overflow), 32'd0);
        chk("sat_clr_drop", 32'(drop_count), 32'd0);
        new_frame = 1'b1;
        clear_overflow = 1'b1;
        @(negedge clk);
        clear_overflow = 1'b0;
        new_frame = 1'b0;
        chk("race_ovf", 32'(overflow), 32'd1);
        chk("race_drop", 32'(drop_count), 32'd1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
